picorv32_sram_resp: RTL and testbench
=====================================

# picorv32_sram_resp

Memory responder for the picorv32 native memory interface, backed by one sky130 OpenRAM single-port macro (1rw port, 32-bit words, byte write mask). It is the far end of the core's `mem_valid`/`mem_ready` handshake. It decodes the request address against a base window and drives the macro's active-low chip-select and write-enable. It returns a single-cycle `mem_ready` pulse with registered read data once the macro's fixed read latency has elapsed.

## Interface
- `ADDR_WIDTH`, 9: macro word-address width (512 words = 2 KiB).
- `BASE_ADDR`, 32'h0000_0000: byte base of the window; must be aligned to 4·2^ADDR_WIDTH.
- `READ_LATENCY`, 1: cycles from macro capture edge to valid `dout0`; legal range 1–4.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  request valid from core.
- `mem_instr`  in  1  request is an instruction fetch.
- `mem_addr`  in  32  byte address; bits [1:0] ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes; 0 = read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1.
- `csb0`  out  1  macro chip select, active low.
- `web0`  out  1  macro write enable, active low.
- `wmask0`  out  4  macro byte mask.
- `addr0`  out  ADDR_WIDTH  macro word address.
- `din0`  out  32  macro write data.
- `dout0`  in  32  macro read data.
- `bus_err`  out  1  present only with `SRAM_RESP_BUS_ERR_EN`; see Configuration.

## Operation
- States: IDLE, RWAIT, DONE.
- IDLE + `mem_valid`: this is the accept cycle.
  - Hit when `mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`.
  - On a hit, the macro ports are driven combinationally in that cycle: `csb0`=0, `web0`=~|`mem_wstrb`, `wmask0`=`mem_wstrb`, `addr0`=`mem_addr[ADDR_WIDTH+1:2]`, `din0`=`mem_wdata`.
- Hit write: IDLE → DONE.
- Hit read: IDLE → RWAIT, loading the latency counter with `READ_LATENCY`. RWAIT decrements the counter each cycle. When the counter reaches 1, `dout0` is captured into `mem_rdata` and the FSM moves to DONE.
- Miss: IDLE → DONE with no macro access; `mem_rdata`=0.
- DONE: `mem_ready`=1 for exactly one cycle, then IDLE. A `mem_valid` seen in DONE belongs to the completing request and is never re-accepted.
- Outside the accept cycle: `csb0`=1 and `web0`=1; `wmask0`, `addr0` and `din0` are 0.
- `mem_rdata` holds its value until the next read capture. It is forced to 0 on writes and misses.
- `mem_valid` falling before DONE (protocol violation): the transaction still completes and `mem_ready` still pulses.
- Fetch with nonzero `mem_wstrb`: treated as a write.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, `csb0`=1, `web0`=1, `bus_err`=0.
- Latency, with the accept cycle as cycle 0:
  - write or miss: `mem_ready` in cycle 1;
  - read: `mem_ready` in cycle READ_LATENCY+1.
- Back-to-back throughput: one write per 2 cycles; one read per READ_LATENCY+2 cycles.
- Reset asserted mid-transaction: the next cycle is IDLE with no `mem_ready`. A macro write already captured is not undone.

## Configuration
- `SRAM_RESP_BUS_ERR_EN` defined:
  - `bus_err` port exists and pulses together with `mem_ready` on a miss.
  - `bus_err` also pulses on a fetch with nonzero `mem_wstrb`; that write is suppressed (`csb0` stays 1).
- Not defined:
  - no `bus_err` port;
  - misses complete silently with `mem_rdata`=0;
  - fetch-writes proceed as normal writes.

## Structure
- `sram_resp_pkg` holds:
  - the state enum (IDLE, RWAIT, DONE);
  - the latency-counter width constant (3 bits);
  - the `SRAM_RESP_MAX_LATENCY` = 4 constant.
- One sub-module, `sram_resp_decode`: combinational hit/word-address decode, parameterised by `ADDR_WIDTH` and `BASE_ADDR`.

## Test plan
- Reset with `mem_valid`=1 held → `mem_ready`=0, `csb0`=1 throughout; the request is accepted on the first cycle after reset drops.
- Write 0xDEADBEEF to 0x0000_0010 with strobes 4'b1111, then read 0x10 with READ_LATENCY=1 → write `mem_ready` in cycle 1; read `mem_ready` in cycle 2 with `mem_rdata`=0xDEADBEEF; macro `addr0`=4.
- Byte write strobe 4'b0100 with data 0x00AA0000 to 0x10, then read 0x10 → 0xDEAABEEF.
- Read with READ_LATENCY=3 → `mem_ready` exactly in cycle 4; `mem_valid` held high through DONE → no second access.
- Access to 0x0000_0800 (miss) → `mem_ready` in cycle 1, `mem_rdata`=0, `csb0` never low; with the macro defined, `bus_err`=1 in the same cycle.
- Reset pulsed in RWAIT → no `mem_ready`; the following read of 0x10 returns correct data.

Source files
------------

// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the picorv32 SRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_e               - responder FSM states
//   SRAM_RESP_CNT_W       - width of the read-latency down-counter
//   SRAM_RESP_MAX_LATENCY - largest supported macro read latency
package sram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int SRAM_RESP_CNT_W       = 3;
    localparam int SRAM_RESP_MAX_LATENCY = 4;

endpackage

// File: rtl/sram_resp_decode.sv
// Combinational address decode: window hit and macro word address.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; it simply follows the address bus.
//
// Ports:
//   mem_addr_i  - byte address from the core (bits [1:0] ignored)
//   hit_o       - address lies inside the BASE_ADDR window
//   word_addr_o - word index into the macro
module sram_resp_decode #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic [31:0]           mem_addr_i,
    output logic                  hit_o,
    output logic [ADDR_WIDTH-1:0] word_addr_o
);

    // Byte offset within a word carries no information for a 32-bit macro.
    logic [1:0] unused_byte_off;
    assign unused_byte_off = mem_addr_i[1:0];

    assign hit_o       = (mem_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign word_addr_o = mem_addr_i[ADDR_WIDTH+1:2];

endmodule

// File: rtl/picorv32_sram_resp.sv
// picorv32 native-bus responder driving one single-port 1rw SRAM macro.
// Latency: write/miss ready in cycle 1, read ready in cycle READ_LATENCY+1 (accept = cycle 0).
// Backpressure: one request in flight; mem_valid is only sampled in IDLE.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb, mem_ready/mem_rdata - picorv32 native bus
//   csb0/web0/wmask0/addr0/din0/dout0                     - SRAM macro port 0
//   bus_err                     - only with SRAM_RESP_BUS_ERR_EN: pulses with
//                                 mem_ready on a miss or on a fetch-write
//                                 (which is then suppressed)
module picorv32_sram_resp
    import sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [3:0]            wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [31:0]           din0,
`ifdef SRAM_RESP_BUS_ERR_EN
    output logic                  bus_err,
`endif
    input  logic [31:0]           dout0
);

    state_e                     state_q;
    logic [SRAM_RESP_CNT_W-1:0] cnt_q;
    logic                       ready_q;
    logic [31:0]                rdata_q;
    logic                       err_q;

    logic                  hit;
    logic [ADDR_WIDTH-1:0] word_addr;

    sram_resp_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decode (
        .mem_addr_i  (mem_addr),
        .hit_o       (hit),
        .word_addr_o (word_addr)
    );

    // Reset gates acceptance so the macro is never selected while reset is held.
    logic accept;
    logic is_write;
    logic access;
    logic err_d;

    assign accept   = (state_q == IDLE) && mem_valid && !reset;
    assign is_write = |mem_wstrb;

`ifdef SRAM_RESP_BUS_ERR_EN
    // A fetch carrying strobes is treated as a faulting request, not a store.
    logic fetch_wr;
    assign fetch_wr = mem_instr && is_write;
    assign access   = accept && hit && !fetch_wr;
    assign err_d    = !hit || fetch_wr;
`else
    // Instruction and data requests are handled identically here.
    logic unused_instr;
    assign unused_instr = mem_instr;
    assign access       = accept && hit;
    assign err_d        = 1'b0;
`endif

    // Macro port is driven only during the accept cycle, otherwise parked.
    assign csb0   = ~access;
    assign web0   = access ? ~is_write : 1'b1;
    assign wmask0 = access ? mem_wstrb : 4'b0000;
    assign addr0  = access ? word_addr : '0;
    assign din0   = access ? mem_wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (access && !is_write) begin
                            state_q <= RWAIT;
                            cnt_q   <= SRAM_RESP_CNT_W'(READ_LATENCY);
                        end else begin
                            // Write, miss or suppressed fetch-write: done next cycle.
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            rdata_q <= 32'h0;
                            err_q   <= err_d;
                        end
                    end
                end
                RWAIT: begin
                    cnt_q <= cnt_q - SRAM_RESP_CNT_W'(1);
                    // Counter value 1 marks the cycle dout0 is valid.
                    if (cnt_q == SRAM_RESP_CNT_W'(1)) begin
                        rdata_q <= dout0;
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    // mem_valid is still high here for the completing request.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

`ifdef SRAM_RESP_BUS_ERR_EN
    assign bus_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_picorv32_sram_resp.sv
// Bench for picorv32_sram_resp: two instances (READ_LATENCY 1 and 3), each
// with a behavioural SRAM macro model; table-driven vectors plus hand sequences.
module tb_picorv32_sram_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        init_mem;
    logic        valid_s [2];
    logic        instr_s [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  wstrb_s [2];
    logic        ready_s [2];
    logic [31:0] rdata_s [2];
    logic        csb_s   [2];
    logic        web_s   [2];
    logic [3:0]  wmask_s [2];
    logic [8:0]  addr0_s [2];
    logic [31:0] din_s   [2];
    logic [31:0] dout_s  [2];
    logic        buserr_s[2];

    picorv32_sram_resp #(.ADDR_WIDTH(9), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .mem_valid(valid_s[0]), .mem_instr(instr_s[0]), .mem_addr(addr_s[0]),
        .mem_wdata(wdata_s[0]), .mem_wstrb(wstrb_s[0]),
        .mem_ready(ready_s[0]), .mem_rdata(rdata_s[0]),
        .csb0(csb_s[0]), .web0(web_s[0]), .wmask0(wmask_s[0]), .addr0(addr0_s[0]),
        .din0(din_s[0]),
`ifdef SRAM_RESP_BUS_ERR_EN
        .bus_err(buserr_s[0]),
`endif
        .dout0(dout_s[0])
    );

    picorv32_sram_resp #(.ADDR_WIDTH(9), .BASE_ADDR(32'h0), .READ_LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset),
        .mem_valid(valid_s[1]), .mem_instr(instr_s[1]), .mem_addr(addr_s[1]),
        .mem_wdata(wdata_s[1]), .mem_wstrb(wstrb_s[1]),
        .mem_ready(ready_s[1]), .mem_rdata(rdata_s[1]),
        .csb0(csb_s[1]), .web0(web_s[1]), .wmask0(wmask_s[1]), .addr0(addr0_s[1]),
        .din0(din_s[1]),
`ifdef SRAM_RESP_BUS_ERR_EN
        .bus_err(buserr_s[1]),
`endif
        .dout0(dout_s[1])
    );

`ifndef SRAM_RESP_BUS_ERR_EN
    assign buserr_s[0] = 1'b0;
    assign buserr_s[1] = 1'b0;
`endif

    // Macro models: capture on the clock edge, data valid L cycles later.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] mem  [512];
        logic [31:0] pipe [4];
        always @(posedge clk) begin
            if (init_mem) begin
                for (int i = 0; i < 512; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
            end else if (!csb_s[g] && !web_s[g]) begin
                for (int b = 0; b < 4; b++)
                    if (wmask_s[g][b]) mem[addr0_s[g]][8*b +: 8] <= din_s[g][8*b +: 8];
            end
            pipe[0] <= 32'hBAD0_BAD0;
            if (!csb_s[g] && web_s[g]) pipe[0] <= mem[addr0_s[g]];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign dout_s[g] = pipe[L-1];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One request on instance sel; mem_valid held until and through DONE.
    task automatic txn(input int sel, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output int lat, output logic [31:0] rdata,
                       output int csb_lows, output logic [8:0] a0, output logic err);
        @(negedge clk);
        reset        = 1'b0;
        valid_s[sel] = 1'b1;
        instr_s[sel] = instr;
        addr_s[sel]  = addr;
        wdata_s[sel] = wdata;
        wstrb_s[sel] = strb;
        #1;
        csb_lows = (csb_s[sel] == 1'b0) ? 1 : 0;
        a0       = addr0_s[sel];
        lat      = -1;
        rdata    = 32'h0;
        err      = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (!csb_s[sel]) csb_lows++;
            if (ready_s[sel]) begin
                lat   = n;
                rdata = rdata_s[sel];
                err   = buserr_s[sel];
                break;
            end
        end
        @(negedge clk);
        valid_s[sel] = 1'b0;
        instr_s[sel] = 1'b0;
        addr_s[sel]  = 32'h0;
        wdata_s[sel] = 32'h0;
        wstrb_s[sel] = 4'h0;
    endtask

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          lat;
        logic [31:0] rdata;
        int          csbl;
        logic [8:0]  a0;
        logic        err;
    } vec_t;

    vec_t tbl [14];

    int          lat, csbl, rdy_seen;
    logic [31:0] rd;
    logic [8:0]  a0;
    logic        err;

    initial begin
        tbl[0]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1, 32'h0,         1, 9'd4,   1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 2, 32'hDEAD_BEEF, 1, 9'd4,   1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0010, 32'h00AA_0000, 4'b0100, 1, 32'h0,         1, 9'd4,   1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 2, 32'hDEAA_BEEF, 1, 9'd4,   1'b0};
        tbl[4]  = '{1'b0, 32'h0000_07FC, 32'h1234_5678, 4'b1111, 1, 32'h0,         1, 9'd511, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_07FC, 32'h0,         4'b0000, 2, 32'h1234_5678, 1, 9'd511, 1'b0};
        tbl[6]  = '{1'b0, 32'h0000_0800, 32'h0,         4'b0000, 1, 32'h0,         0, 9'd0,   1'b1};
        tbl[7]  = '{1'b0, 32'hFFFF_FFF0, 32'h1111_1111, 4'b1111, 1, 32'h0,         0, 9'd0,   1'b1};
        tbl[8]  = '{1'b0, 32'h0000_0013, 32'h0,         4'b0000, 2, 32'hDEAA_BEEF, 1, 9'd4,   1'b0};
        tbl[9]  = '{1'b0, 32'h0000_0012, 32'h0000_00CC, 4'b0001, 1, 32'h0,         1, 9'd4,   1'b0};
        tbl[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 2, 32'hDEAA_BECC, 1, 9'd4,   1'b0};
        tbl[11] = '{1'b1, 32'h0000_07FC, 32'h0,         4'b0000, 2, 32'h1234_5678, 1, 9'd511, 1'b0};
`ifdef SRAM_RESP_BUS_ERR_EN
        tbl[12] = '{1'b1, 32'h0000_0000, 32'h5555_5555, 4'b1111, 1, 32'h0,         0, 9'd0,   1'b1};
        tbl[13] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 2, 32'hA5A5_0000, 1, 9'd0,   1'b0};
`else
        tbl[12] = '{1'b1, 32'h0000_0000, 32'h5555_5555, 4'b1111, 1, 32'h0,         1, 9'd0,   1'b0};
        tbl[13] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 2, 32'h5555_5555, 1, 9'd0,   1'b0};
`endif

        // Reset held with a read request pending on both instances.
        reset    = 1'b1;
        init_mem = 1'b1;
        for (int s = 0; s < 2; s++) begin
            valid_s[s] = 1'b1;
            instr_s[s] = 1'b0;
            addr_s[s]  = 32'h10;
            wdata_s[s] = 32'h0;
            wstrb_s[s] = 4'h0;
        end
        @(negedge clk);
        init_mem = 1'b0;
        rdy_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int s = 0; s < 2; s++) begin
                if (ready_s[s] || !csb_s[s]) rdy_seen++;
            end
        end
        chk("reset_no_ready_no_csb", 32'(rdy_seen), 32'd0);
        chk("reset_rdata_l1", rdata_s[0], 32'h0);
        chk("reset_web_l1", {31'h0, web_s[0]}, 32'd1);
`ifdef SRAM_RESP_BUS_ERR_EN
        chk("reset_bus_err", {31'h0, buserr_s[0]}, 32'd0);
`endif
        @(negedge clk);
        valid_s[1] = 1'b0;

        // The held request is accepted in the first cycle after reset drops.
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, csbl, a0, err);
        chk("post_reset_lat", 32'(lat), 32'd2);
        chk("post_reset_rdata", rd, 32'hA5A5_0004);
        chk("post_reset_csb", 32'(csbl), 32'd1);

        for (int i = 0; i < 14; i++) begin
            txn(0, tbl[i].instr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, lat, rd, csbl, a0, err);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("v%0d_csb_lows", i), 32'(csbl), 32'(tbl[i].csbl));
            chk($sformatf("v%0d_addr0", i), {23'h0, a0}, {23'h0, tbl[i].a0});
`ifdef SRAM_RESP_BUS_ERR_EN
            chk($sformatf("v%0d_bus_err", i), {31'h0, err}, {31'h0, tbl[i].err});
`endif
        end

        // READ_LATENCY=3: ready in cycle 4, valid held through DONE, no re-access.
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, csbl, a0, err);
        chk("l3_lat", 32'(lat), 32'd4);
        chk("l3_rdata", rd, 32'hA5A5_0004);
        chk("l3_single_access", 32'(csbl), 32'd1);
        @(posedge clk); #1;
        chk("l3_rdata_hold", rdata_s[1], 32'hA5A5_0004);
        chk("l3_ready_one_cycle", {31'h0, ready_s[1]}, 32'd0);

        // Reset pulsed while waiting for read data.
        @(negedge clk);
        valid_s[1] = 1'b1;
        addr_s[1]  = 32'h7FC;
        wstrb_s[1] = 4'h0;
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b1;
        valid_s[1] = 1'b0;
        addr_s[1]  = 32'h0;
        @(negedge clk);
        reset    = 1'b0;
        rdy_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ready_s[1]) rdy_seen++;
        end
        chk("rst_rwait_no_ready", 32'(rdy_seen), 32'd0);
        chk("rst_rwait_rdata_cleared", rdata_s[1], 32'h0);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, csbl, a0, err);
        chk("rst_rwait_next_lat", 32'(lat), 32'd4);
        chk("rst_rwait_next_rdata", rd, 32'hA5A5_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
